fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction fetch stage for the arv core.
- Generates sequential PCs from a reset vector and issues word reads over a request/grant + response-valid memory interface with multi-cycle latency.
- Buffers returned instructions with their PCs in a FIFO_DEPTH-entry prefetch queue and hands them to decode with a valid/ready handshake.
- A redirect (branch/jump) flushes the queue and discards in-flight responses.

Parameters:
XLEN, 32, instruction/data word width
MEMWIDTH, 32, address width
RESET_PC, 0, first fetch address after reset (word aligned)
FIFO_DEPTH, 4, prefetch queue entries and also max outstanding requests (power of 2, >=2)

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous active-high reset
redirect_i  in  1  redirect fetch to redirect_pc_i this cycle
redirect_pc_i  in  MEMWIDTH  new fetch address; bits [1:0] ignored (forced 0)
mem_req_o  out  1  read request valid
mem_addr_o  out  MEMWIDTH  request word address
mem_gnt_i  in  1  request accepted this cycle (only meaningful while mem_req_o=1)
mem_rvalid_i  in  1  read data valid; responses return in request order
mem_rdata_i  in  XLEN  read data
instr_valid_o  out  1  instruction available to decode
instr_o  out  XLEN  instruction word at queue head
instr_pc_o  out  MEMWIDTH  PC of instr_o
instr_ready_i  in  1  decode consumes head when instr_valid_o=1

Behaviour:
- State: fpc (next address to request), rpc (PC of next kept response), pend (in-flight count, 0..FIFO_DEPTH), drop (responses to discard, 0..FIFO_DEPTH), FIFO of {pc, instr}, count 0..FIFO_DEPTH.
- Reset (rst_i=1): fpc=rpc=RESET_PC, pend=drop=count=0, mem_req_o=0, instr_valid_o=0. Reset overrides redirect and discards all in-flight transactions.
- Issue:
  - mem_req_o=1 iff not in reset, redirect_i=0, and count+pend-drop < FIFO_DEPTH. This credit rule guarantees every kept response has a free slot.
  - mem_addr_o=fpc.
  - mem_req_o holds, with a stable address, until granted.
  - Grant: fpc+=4 (wraps modulo 2^MEMWIDTH), pend+=1.
- Response (mem_rvalid_i=1): pend-=1.
  - drop>0: data discarded, drop-=1.
  - Otherwise: {rpc, mem_rdata_i} pushed, rpc+=4.
  - Same-cycle grant and response: pend unchanged.
- Output:
  - instr_valid_o = (count!=0) & ~redirect_i; instr_o/instr_pc_o come from the FIFO head.
  - Pop when instr_valid_o & instr_ready_i.
  - Push and pop in the same cycle are both honoured.
  - Minimum latency: grant at cycle N, rvalid at N+k, instr_valid_o at N+k+1.
- Redirect (redirect_i=1, rst_i=0):
  - FIFO cleared; any pop that cycle is ignored.
  - fpc=rpc={redirect_pc_i[MEMWIDTH-1:2],2'b00}.
  - drop = pend - mem_rvalid_i, the new value of pend after any response this cycle; the response in the redirect cycle itself is discarded.
  - Requests from the new PC start the next cycle.
  - Back-to-back redirects: the last one wins; drop recomputed the same way.
- Only pend/drop bound the number of outstanding requests. Memory must not return more responses than were granted; behaviour is undefined otherwise.
- No combinational path from mem_rvalid_i/mem_rdata_i to outputs. redirect_i reaches instr_valid_o and mem_req_o combinationally.

Test Plan:
- Reset release, RESET_PC=0x100, memory latency 1, always grant, instr_ready_i=1 -> requests 0x100,0x104,0x108... on consecutive cycles; instr_pc_o sequence 0x100,0x104,... with matching data, first instr_valid_o 2 cycles after first grant.
- instr_ready_i=0 forever, FIFO_DEPTH=4, latency 3 -> exactly 4 grants (0x100..0x10C), mem_req_o then stays 0; raising ready drains 4 in order, then fetching resumes at 0x110.
- Latency 3, redirect to 0x2002 while pend=3 -> next request address 0x2000; the 3 stale responses are dropped; first instr_pc_o after redirect is 0x2000.
- Redirect in the same cycle as a response and a pop, count=2 -> FIFO empty next cycle, instr_valid_o=0 during the redirect cycle, response discarded, drop=pend-1.
- mem_gnt_i held 0 for 5 cycles -> mem_req_o=1 and mem_addr_o stable throughout; fpc advances only on the grant cycle.
- rst_i asserted mid-stream with pend=2 -> all outputs 0 next cycle; the first request after release is RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited memory reads,
// prefetch queue toward decode, and redirect with discard of in-flight responses.
module fetch_unit #(
  parameter int                    XLEN       = 32,
  parameter int                    MEMWIDTH   = 32,
  parameter logic [MEMWIDTH-1:0]   RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                redirect_i,
  input  logic [MEMWIDTH-1:0] redirect_pc_i,
  output logic                mem_req_o,
  output logic [MEMWIDTH-1:0] mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [XLEN-1:0]     mem_rdata_i,
  output logic                instr_valid_o,
  output logic [XLEN-1:0]     instr_o,
  output logic [MEMWIDTH-1:0] instr_pc_o,
  input  logic                instr_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [MEMWIDTH-1:0] fpc_q, fpc_d, rpc_q, rpc_d;
  logic [CW-1:0]       pend_q, pend_d, drop_q, drop_d, cnt_q, cnt_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MEMWIDTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [XLEN-1:0]     fifo_data_q [FIFO_DEPTH];

  logic [CW:0]         credit_use;
  logic                credit_ok, gnt, keep, push, pop;
  logic [MEMWIDTH-1:0] redir_pc;

  // pend never falls below drop, so the subtraction cannot underflow.
  assign credit_use = {1'b0, cnt_q} + {1'b0, pend_q} - {1'b0, drop_q};
  assign credit_ok  = credit_use < (CW+1)'(FIFO_DEPTH);
  assign redir_pc   = redirect_pc_i & ~MEMWIDTH'(3);

  assign mem_req_o     = ~rst_i & ~redirect_i & credit_ok;
  assign mem_addr_o    = fpc_q;
  assign instr_valid_o = (cnt_q != '0) & ~redirect_i;
  assign instr_o       = fifo_data_q[rd_ptr_q];
  assign instr_pc_o    = fifo_pc_q[rd_ptr_q];

  assign gnt  = mem_req_o & mem_gnt_i;
  assign keep = mem_rvalid_i & (drop_q == '0);
  assign push = keep & ~redirect_i;
  assign pop  = instr_valid_o & instr_ready_i;

  always_comb begin
    fpc_d    = gnt  ? fpc_q + MEMWIDTH'(4) : fpc_q;
    rpc_d    = push ? rpc_q + MEMWIDTH'(4) : rpc_q;
    pend_d   = pend_q + CW'(gnt) - CW'(mem_rvalid_i);
    drop_d   = drop_q - CW'(mem_rvalid_i && (drop_q != '0));
    cnt_d    = cnt_q + CW'(push) - CW'(pop);
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    if (redirect_i) begin
      // Everything still in flight belongs to the old stream; the response
      // arriving this very cycle is thrown away as well.
      fpc_d    = redir_pc;
      rpc_d    = redir_pc;
      pend_d   = pend_q - CW'(mem_rvalid_i);
      drop_d   = pend_q - CW'(mem_rvalid_i);
      cnt_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fpc_q    <= RESET_PC;
      rpc_q    <= RESET_PC;
      pend_q   <= '0;
      drop_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rpc_q    <= rpc_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      fifo_pc_q[wr_ptr_q]   <= rpc_q;
      fifo_data_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(push && !pop && cnt_q == CW'(FIFO_DEPTH)));
  a_pend_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    (pend_q <= CW'(FIFO_DEPTH)) && (drop_q <= pend_q));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory model with configurable latency, pop scoreboard,
// a redirect vector table and hand-written corner sequences.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1, redirect = 1'b0, gnt = 1'b0, rvalid = 1'b0, ready = 1'b0;
  logic [31:0] redirect_pc = '0, rdata = '0;
  logic        mem_req, instr_valid;
  logic [31:0] mem_addr, instr, instr_pc;

  fetch_unit #(.XLEN(32), .MEMWIDTH(32), .RESET_PC(32'h100), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(gnt),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
    .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(ready));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] tgt; logic [31:0] addr; logic [31:0] nxt; } vec_t;

  ent_t        exp_q[$];
  mreq_t       mem_q[$];
  logic [31:0] glog[$], plog[$];
  int          cyc = 0, lat = 1, n_vec = 0, n_err = 0;

  function automatic logic [31:0] mdata(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Memory response driver: in-order, each response due lat cycles after its grant.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    rvalid = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rdata  = rvalid ? mdata(mem_q[0].addr) : 32'hDEAD_BEEF;
  end

  // Monitor: records grants, retires responses, checks every pop against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      mem_q.delete();
    end else begin
      if (instr_valid && ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pop_unexpected: got pc %h, nothing expected", instr_pc);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          if (instr_pc !== e.pc || instr !== e.data) begin
            n_err++;
            $display("FAIL pop_data: got pc %h data %h expected pc %h data %h",
                     instr_pc, instr, e.pc, e.data);
          end
        end
        plog.push_back(instr_pc);
      end
      if (rvalid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (redirect) exp_q.delete();
      if (mem_req && gnt) begin
        mem_q.push_back('{addr: mem_addr, due: cyc + lat});
        exp_q.push_back('{pc: mem_addr, data: mdata(mem_addr)});
        glog.push_back(mem_addr);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    repeat (3) tick();
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_vld", {31'b0, instr_valid}, 32'd0);
    rst = 1'b0;
    glog.delete();
    plog.delete();
    #1;
    chk("rel_req", {31'b0, mem_req}, 32'd1);
    chk("rel_addr", mem_addr, 32'h100);
  endtask

  vec_t tbl[3];

  initial begin
    tbl[0] = '{tgt: 32'h0000_2002, addr: 32'h0000_2000, nxt: 32'h0000_2004};
    tbl[1] = '{tgt: 32'h0000_3FFF, addr: 32'h0000_3FFC, nxt: 32'h0000_4000};
    tbl[2] = '{tgt: 32'hFFFF_FFFE, addr: 32'hFFFF_FFFC, nxt: 32'h0000_0000};

    // Streaming at latency 1, always granted, always ready.
    lat = 1; gnt = 1'b1; ready = 1'b1;
    do_reset();
    tick();
    chk("s1_addr1", mem_addr, 32'h104);
    chk("s1_vld_early", {31'b0, instr_valid}, 32'd0);
    tick();
    chk("s1_vld_first", {31'b0, instr_valid}, 32'd1);
    chk("s1_pc_first", instr_pc, 32'h100);
    repeat (15) tick();
    chk("s1_pc5", plog[5], 32'h114);

    // Decode stalled: credit limit caps outstanding + buffered at 4.
    lat = 3; ready = 1'b0;
    do_reset();
    repeat (30) tick();
    chk("s2_grants", glog.size(), 32'd4);
    chk("s2_last_gnt", glog[3], 32'h10C);
    chk("s2_req_off", {31'b0, mem_req}, 32'd0);
    chk("s2_queued", exp_q.size(), 32'd4);
    ready = 1'b1;
    repeat (12) tick();
    chk("s2_drain0", plog[0], 32'h100);
    chk("s2_drain3", plog[3], 32'h10C);
    chk("s2_resume", glog[4], 32'h110);

    // Redirect table while streaming at latency 3.
    for (int i = 0; i < 3; i++) begin
      repeat (10) tick();
      redirect_pc = tbl[i].tgt;
      redirect = 1'b1;
      #1;
      chk("rd_req_off", {31'b0, mem_req}, 32'd0);
      chk("rd_vld_off", {31'b0, instr_valid}, 32'd0);
      tick();
      redirect = 1'b0;
      plog.delete();
      #1;
      chk("rd_req", {31'b0, mem_req}, 32'd1);
      chk("rd_addr", mem_addr, tbl[i].addr);
      repeat (12) tick();
      chk("rd_pc0", plog[0], tbl[i].addr);
      chk("rd_pc1", plog[1], tbl[i].nxt);
    end

    // Redirect coinciding with a response and a pop, two entries queued.
    lat = 2; ready = 1'b0;
    do_reset();
    repeat (4) tick();
    chk("s4_vld_before", {31'b0, instr_valid}, 32'd1);
    ready = 1'b1;
    redirect_pc = 32'h4000;
    redirect = 1'b1;
    #1;
    chk("s4_vld_redir", {31'b0, instr_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    plog.delete();
    #1;
    chk("s4_flushed", {31'b0, instr_valid}, 32'd0);
    chk("s4_addr", mem_addr, 32'h4000);
    tick();
    chk("s4_dropped", {31'b0, instr_valid}, 32'd0);
    repeat (12) tick();
    chk("s4_pc0", plog[0], 32'h4000);

    // Grant withheld: request and address must hold.
    lat = 1; gnt = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      chk("s5_req_hold", {31'b0, mem_req}, 32'd1);
      chk("s5_addr_hold", mem_addr, 32'h100);
      tick();
    end
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    #1;
    chk("s5_addr_step", mem_addr, 32'h104);
    chk("s5_glog", glog.size(), 32'd1);
    gnt = 1'b1;

    // Reset mid-stream with two in flight.
    lat = 2;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    chk("s6_req", {31'b0, mem_req}, 32'd0);
    chk("s6_vld", {31'b0, instr_valid}, 32'd0);
    do_reset();
    repeat (10) tick();
    chk("s6_pc0", plog[0], 32'h100);

    // Stop granting; everything outstanding must come back and be consumed.
    gnt = 1'b0;
    repeat (12) tick();
    chk("drain_empty", exp_q.size(), 32'd0);
    chk("drain_vld", {31'b0, instr_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
